// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the IF-stage fetch unit.
package instruction_fetch_unit_pkg;

  typedef enum logic {StReq, StWait} fetch_state_e;

  localparam logic [31:0] DefaultResetPc  = 32'h0000_0000;
  localparam logic [31:0] DefaultNopInstr = 32'h0000_0000;
  localparam logic [31:0] PcIncr          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry head/skid queue of fetched {pc, instr} words.
module fetch_skid_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         head_valid,
  output fetch_entry_t head_data,
  output logic         skid_valid
);

  logic         head_valid_q, head_valid_d;
  logic         skid_valid_q, skid_valid_d;
  fetch_entry_t head_q, head_d;
  fetch_entry_t skid_q, skid_d;
  logic         pop_eff;

  assign pop_eff = pop & head_valid_q;

  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    head_d       = head_q;
    skid_d       = skid_q;
    if (clear) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (pop_eff) begin
        head_valid_d = 1'b0;
      end
      // Skid refills the head first; a same-cycle push then lands in skid.
      if (pop_eff && skid_valid_q) begin
        head_valid_d = 1'b1;
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end
      if (push) begin
        if (!head_valid_d) begin
          head_valid_d = 1'b1;
          head_d       = push_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_d       = push_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head_data  = head_q;
  assign skid_valid = skid_valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the fetch PC, issues single-outstanding imem requests, feeds IF/ID.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefaultResetPc,
  parameter logic [31:0] NOP_INSTR = DefaultNopInstr
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        flush_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  held_addr_q;
  logic         kill_q, kill_d;
  logic         held_q;
  logic         granted, rsp, push, pop;
  logic         head_valid, skid_valid;
  fetch_entry_t head_data, push_data;

  // A request left ungranted keeps its address even if a branch moves fetch_pc.
  assign imem_addr = held_q ? held_addr_q : fetch_pc_q;
  assign imem_req  = rst && (state_q == StReq) && (held_q || !skid_valid);
  assign granted   = imem_req & imem_gnt;
  assign rsp       = imem_rvalid & (state_q == StWait);
  assign push      = rsp & ~kill_q & ~branch_taken;
  assign pop       = head_valid & ~freeze;
  assign flush_out = branch_taken;

  assign push_data.pc    = req_pc_q + PcIncr;
  assign push_data.instr = imem_rdata;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    unique case (state_q)
      StReq:  if (granted) begin
        state_d  = StWait;
        req_pc_d = imem_addr;
      end
      StWait: if (imem_rvalid) state_d = StReq;
    endcase
    if (rsp) kill_d = 1'b0;
    if (push) fetch_pc_d = req_pc_q + PcIncr;
    if (branch_taken) begin
      fetch_pc_d = branch_addr & ~32'h3;
      if ((state_q == StWait && !imem_rvalid) || (state_q == StReq && imem_req)) begin
        kill_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StReq;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      kill_q      <= 1'b0;
      held_q      <= 1'b0;
      held_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      held_q     <= imem_req & ~imem_gnt;
      if (imem_req && !imem_gnt) held_addr_q <= imem_addr;
    end
  end

  fetch_skid_buffer u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (branch_taken),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .skid_valid (skid_valid)
  );

  assign valid_out       = head_valid;
  assign pc_out          = head_valid ? head_data.pc : '0;
  assign instruction_out = head_valid ? head_data.instr : NOP_INSTR;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed per-cycle vectors for the fetch unit, plus wrap-around and async-reset sequences.
module tb_instruction_fetch_unit;

  localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002, WC = 32'hC000_0003;
  localparam logic [31:0] WD = 32'hD000_0004, WE = 32'hE000_0005, WF = 32'hF000_0006;
  localparam logic [31:0] WG = 32'h1000_0007, WX = 32'h2000_0008, WH = 32'h3000_0009;
  localparam logic [31:0] WI = 32'h4000_000A, WJ = 32'h5000_000B, WK = 32'h6000_000C;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int NumVec = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0, branch_taken = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] branch_addr = '0, imem_rdata = '0;

  logic        imem_req, valid_out, flush_out;
  logic [31:0] imem_addr, pc_out, instruction_out;
  logic        w_req, w_valid, w_flush;
  logic [31:0] w_addr, w_pc, w_instr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit u_dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .flush_out       (flush_out)
  );

  instruction_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (w_req),
    .imem_addr       (w_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_out          (w_pc),
    .instruction_out (w_instr),
    .valid_out       (w_valid),
    .flush_out       (w_flush)
  );

  typedef struct {
    logic        fr, br;
    logic [31:0] baddr;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc, einstr;
  } vec_t;

  vec_t vecs [NumVec];

  function automatic vec_t mk(logic fr, logic br, logic [31:0] baddr, logic gnt, logic rv,
                              logic [31:0] rdata, logic ereq, logic [31:0] eaddr,
                              logic evalid, logic [31:0] epc, logic [31:0] einstr);
    vec_t v;
    v.fr = fr; v.br = br; v.baddr = baddr; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.einstr = einstr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Stream, held-request branch, freeze, branch in WAIT, branch+rvalid+freeze.
    vecs[0]  = mk(0, 0, 0,        1, 0, 0,  1, 32'h000, 0, 0,       NOP);
    vecs[1]  = mk(0, 0, 0,        0, 1, WA, 0, 0,       0, 0,       NOP);
    vecs[2]  = mk(0, 0, 0,        1, 0, 0,  1, 32'h004, 1, 32'h004, WA);
    vecs[3]  = mk(0, 0, 0,        0, 1, WB, 0, 0,       0, 0,       NOP);
    vecs[4]  = mk(0, 0, 0,        1, 0, 0,  1, 32'h008, 1, 32'h008, WB);
    vecs[5]  = mk(0, 0, 0,        0, 1, WC, 0, 0,       0, 0,       NOP);
    vecs[6]  = mk(0, 0, 0,        0, 0, 0,  1, 32'h00C, 1, 32'h00C, WC);
    vecs[7]  = mk(0, 1, 32'h200,  0, 0, 0,  1, 32'h00C, 0, 0,       NOP);
    vecs[8]  = mk(0, 0, 0,        0, 0, 0,  1, 32'h00C, 0, 0,       NOP);
    vecs[9]  = mk(0, 0, 0,        1, 0, 0,  1, 32'h00C, 0, 0,       NOP);
    vecs[10] = mk(0, 0, 0,        0, 1, WD, 0, 0,       0, 0,       NOP);
    vecs[11] = mk(0, 0, 0,        1, 0, 0,  1, 32'h200, 0, 0,       NOP);
    vecs[12] = mk(0, 0, 0,        0, 1, WE, 0, 0,       0, 0,       NOP);
    vecs[13] = mk(1, 0, 0,        1, 0, 0,  1, 32'h204, 1, 32'h204, WE);
    vecs[14] = mk(1, 0, 0,        0, 1, WF, 0, 0,       1, 32'h204, WE);
    vecs[15] = mk(1, 0, 0,        0, 0, 0,  0, 0,       1, 32'h204, WE);
    vecs[16] = mk(1, 0, 0,        0, 0, 0,  0, 0,       1, 32'h204, WE);
    vecs[17] = mk(1, 0, 0,        0, 0, 0,  0, 0,       1, 32'h204, WE);
    vecs[18] = mk(0, 0, 0,        0, 0, 0,  0, 0,       1, 32'h204, WE);
    vecs[19] = mk(0, 0, 0,        1, 0, 0,  1, 32'h208, 1, 32'h208, WF);
    vecs[20] = mk(0, 0, 0,        0, 1, WG, 0, 0,       0, 0,       NOP);
    vecs[21] = mk(0, 0, 0,        1, 0, 0,  1, 32'h20C, 1, 32'h20C, WG);
    vecs[22] = mk(0, 1, 32'h103,  0, 0, 0,  0, 0,       0, 0,       NOP);
    vecs[23] = mk(0, 0, 0,        0, 1, WX, 0, 0,       0, 0,       NOP);
    vecs[24] = mk(0, 0, 0,        1, 0, 0,  1, 32'h100, 0, 0,       NOP);
    vecs[25] = mk(0, 0, 0,        0, 1, WH, 0, 0,       0, 0,       NOP);
    vecs[26] = mk(1, 0, 0,        1, 0, 0,  1, 32'h104, 1, 32'h104, WH);
    vecs[27] = mk(1, 1, 32'h300,  0, 1, WI, 0, 0,       1, 32'h104, WH);
    vecs[28] = mk(0, 0, 0,        0, 0, 0,  1, 32'h300, 0, 0,       NOP);
    vecs[29] = mk(0, 0, 0,        1, 0, 0,  1, 32'h300, 0, 0,       NOP);
    vecs[30] = mk(0, 0, 0,        0, 1, WJ, 0, 0,       0, 0,       NOP);
    vecs[31] = mk(0, 0, 0,        0, 0, 0,  1, 32'h304, 1, 32'h304, WJ);

    // Reset state, with flush following branch_taken even in reset.
    @(negedge clk);
    branch_taken = 1'b1;
    #1;
    check("rst req", {31'b0, imem_req}, 32'd0);
    check("rst valid", {31'b0, valid_out}, 32'd0);
    check("rst pc", pc_out, 32'd0);
    check("rst instr", instruction_out, NOP);
    check("rst flush", {31'b0, flush_out}, 32'd1);
    check("rst wrap req", {31'b0, w_req}, 32'd0);
    @(negedge clk);
    branch_taken = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      freeze       = vecs[i].fr;
      branch_taken = vecs[i].br;
      branch_addr  = vecs[i].baddr;
      imem_gnt     = vecs[i].gnt;
      imem_rvalid  = vecs[i].rv;
      imem_rdata   = vecs[i].rdata;
      #1;
      check($sformatf("v%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].ereq});
      if (vecs[i].ereq) check($sformatf("v%0d addr", i), imem_addr, vecs[i].eaddr);
      check($sformatf("v%0d valid", i), {31'b0, valid_out}, {31'b0, vecs[i].evalid});
      if (vecs[i].evalid) check($sformatf("v%0d pc", i), pc_out, vecs[i].epc);
      check($sformatf("v%0d instr", i), instruction_out, vecs[i].einstr);
      check($sformatf("v%0d flush", i), {31'b0, flush_out}, {31'b0, vecs[i].br});
    end

    // Wrap-around from RESET_PC=FFFF_FFFC, then async reset mid-WAIT.
    @(negedge clk);
    {freeze, branch_taken, imem_gnt, imem_rvalid} = '0;
    branch_addr = '0;
    imem_rdata  = '0;
    rst = 1'b0;
    #1;
    check("w0 rst valid", {31'b0, w_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b1;
    #1;
    check("w1 req", {31'b0, w_req}, 32'd1);
    check("w1 addr", w_addr, 32'hFFFF_FFFC);
    check("w1 main addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = WK;
    #1;
    check("w2 req", {31'b0, w_req}, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    freeze      = 1'b1;
    imem_gnt    = 1'b1;
    #1;
    check("w3 valid", {31'b0, w_valid}, 32'd1);
    check("w3 pc wrap", w_pc, 32'h0000_0000);
    check("w3 instr", w_instr, WK);
    check("w3 addr wrap", w_addr, 32'h0000_0000);
    check("w3 main pc", pc_out, 32'h4);
    @(negedge clk);
    imem_gnt = 1'b0;
    #1;
    check("w4 wait req", {31'b0, w_req}, 32'd0);
    check("w4 valid", {31'b0, w_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("w4 async valid", {31'b0, w_valid}, 32'd0);
    check("w4 async pc", w_pc, 32'd0);
    check("w4 async instr", w_instr, NOP);
    check("w4 async main valid", {31'b0, valid_out}, 32'd0);
    check("w4 async main instr", instruction_out, NOP);
    @(negedge clk);
    rst    = 1'b1;
    freeze = 1'b0;
    @(negedge clk);
    #1;
    check("w5 req", {31'b0, w_req}, 32'd1);
    check("w5 addr", w_addr, 32'hFFFF_FFFC);
    check("w5 valid", {31'b0, w_valid}, 32'd0);
    check("w5 main req", {31'b0, imem_req}, 32'd1);
    check("w5 main addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF-stage producer for the IF/ID pipeline register. Owns the fetch PC and issues requests on a variable-latency instruction-memory port (one outstanding request max).
- Buffers returned words in a 2-deep output queue: a head slot driven onto the outputs, plus a skid slot.
- Presents {pc+4, instruction} to the IF/ID register and drives that register's flush on a taken branch from EX.
- Honours the hazard-unit freeze.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0000, instruction_out value when no valid word is presented

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
freeze  in  1  hazard stall; IF/ID does not capture this cycle
branch_taken  in  1  one-cycle pulse from EX: redirect fetch
branch_addr  in  32  branch target; bits [1:0] forced to 0 internally
imem_req  out  1  request valid
imem_addr  out  32  word-aligned request address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid (one per granted request, in order, >=1 cycle after gnt)
imem_rdata  in  32  response instruction
pc_out  out  32  address of presented instruction + 4
instruction_out  out  32  presented instruction, NOP_INSTR when invalid
valid_out  out  1  pc_out/instruction_out hold a real fetched word
flush_out  out  1  drives IF/ID flush; combinational copy of branch_taken

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FSM=REQ; kill=0; both queue slots invalid.
  - imem_req=0 while rst is low; pc_out=0, instruction_out=NOP_INSTR, valid_out=0.
  - flush_out follows branch_taken.
- FSM states: REQ, WAIT.
  - REQ: imem_req=1 only when the skid slot is invalid; imem_addr=fetch_pc. With req&gnt, go to WAIT and record req_pc=fetch_pc.
  - Once asserted, imem_addr and imem_req are held stable until gnt, even across a branch.
  - WAIT: imem_req=0. On imem_rvalid, go to REQ.
- Consume: a cycle with valid_out=1 and freeze=0 consumes the head entry.
- Response write (rvalid, kill=0, no branch this cycle):
  - Entry = {req_pc+4, rdata}; fetch_pc <= req_pc+4.
  - Entry goes to the head if the head is empty or being consumed; otherwise it goes to skid.
  - On consume with skid valid, skid moves to head.
  - At most one of {response, skid} enters the head per cycle. A response that cannot enter the head goes to skid, which is guaranteed free by the issue rule.
- Latency: gnt in cycle N, rvalid in cycle N+k, valid_out=1 at cycle N+k+1 (registered outputs).
- Branch (branch_taken=1; priority over freeze, consume and response write):
  - fetch_pc <= {branch_addr[31:2],2'b00}; head and skid invalidated next cycle.
  - Outstanding or in-flight request (WAIT, or REQ with req=1 and gnt=0, or REQ with req&gnt this cycle): kill<=1.
  - If rvalid arrives in the same cycle as the branch, that response is dropped and kill stays 0.
- Kill: a response arriving with kill=1 is dropped, kill<=0, state goes to REQ, fetch_pc unchanged. In the held-request case, the granted request is killed; the next request uses the branch target.
- Freeze: no effect on requests. Outputs hold their values; a response fills skid. Once skid is full, no new request issues.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000; pc_out likewise wraps mod 2^32.
- Reset mid-transaction: the outstanding request is abandoned; imem is reset by the same rst.

Decomposition:
- Shared package: fetch FSM state enum {REQ, WAIT}; the NOP_INSTR and RESET_PC defaults; the PC increment constant 32'd4.
- One sub-module is natural: fetch_skid_buffer, a 2-entry head/skid queue of {pc,instr} with push, pop and clear.

Test Plan:
- Zero-latency stream: gnt=1 always, rvalid one cycle after gnt, freeze=0, RESET_PC=0, words A,B,C -> pc_out=4,8,12 with instruction_out=A,B,C on consecutive valid cycles; imem_addr=0,4,8.
- Freeze backpressure: freeze=1 for 5 cycles while words arrive -> outputs hold word A, skid holds B, imem_req stays 0 while skid is full; release -> B then C with no loss or duplication.
- Branch during WAIT: branch_taken with branch_addr=32'h0000_0103 -> flush_out=1 that cycle. The pending rvalid word is dropped, next imem_addr=32'h0000_0100, and the first valid output has pc_out=32'h104.
- Branch coincident with rvalid and with freeze=1 -> response dropped, queue emptied, valid_out=0 next cycle, kill=0, and the fetch at the target issues the next cycle.
- Branch while request held (gnt=0 for 3 cycles) -> imem_addr stays at the old PC until gnt, that response is discarded, and the next request carries the target.
- Wrap plus async reset: RESET_PC=32'hFFFF_FFFC -> first pc_out=0, next imem_addr=0. Asserting rst mid-WAIT -> all outputs reset immediately (asynchronously), and fetch restarts at RESET_PC after release.
